// File: rtl/dest_fifo_reader_pkg.sv
// Shared types for the destination FIFO read engine: FSM encoding and
// destination tags used on out_dest.
package dest_fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      PAUSE = 2'd2,
      ERROR = 2'd3
   } state_e;

   localparam logic DEST_D0 = 1'b0;
   localparam logic DEST_D1 = 1'b1;

   // One-hot grant {D1, D0} to destination tag.
   function automatic logic gnt_to_dest(input logic [1:0] gnt);
      if (gnt[1]) begin
         return DEST_D1;
      end else begin
         return DEST_D0;
      end
   endfunction

endpackage

// File: rtl/dest_fifo_reader_if.sv
// Bus between the two destination FIFOs, the read engine and downstream.
// master = read engine view, slave = FIFO/downstream view.
interface dest_fifo_reader_if #(
   parameter int BW    = 6,
   parameter int CNT_W = 5
);
   logic             D0_empty;
   logic [BW-1:0]    D0_data_out;
   logic             D0_error_output;
   logic             D1_empty;
   logic [BW-1:0]    D1_data_out;
   logic             D1_error_output;
   logic             out_pause;
   logic             D0_rd;
   logic             D1_rd;
   logic [BW-1:0]    out_data;
   logic             out_valid;
   logic             out_dest;
   logic [CNT_W-1:0] cnt_D0;
   logic [CNT_W-1:0] cnt_D1;
   logic             error;
   logic             idle;

   modport master (
      input  D0_empty, D0_data_out, D0_error_output,
      input  D1_empty, D1_data_out, D1_error_output,
      input  out_pause,
      output D0_rd, D1_rd, out_data, out_valid, out_dest,
      output cnt_D0, cnt_D1, error, idle
   );

   modport slave (
      output D0_empty, D0_data_out, D0_error_output,
      output D1_empty, D1_data_out, D1_error_output,
      output out_pause,
      input  D0_rd, D1_rd, out_data, out_valid, out_dest,
      input  cnt_D0, cnt_D1, error, idle
   );
endinterface

// File: rtl/dest_fifo_reader_rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer always moves to the
// requester that was not just served, so a lone requester leaves it primed
// for the other side.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic ptr_q;
   logic ptr_d;

   // Grant selection and next pointer.
   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
      if (en_i) begin
         case (req_i)
            2'b01: begin
               gnt_o = 2'b01;
               ptr_d = 1'b1;
            end
            2'b10: begin
               gnt_o = 2'b10;
               ptr_d = 1'b0;
            end
            2'b11: begin
               if (ptr_q) begin
                  gnt_o = 2'b10;
                  ptr_d = 1'b0;
               end else begin
                  gnt_o = 2'b01;
                  ptr_d = 1'b1;
               end
            end
            default: begin
               gnt_o = 2'b00;
               ptr_d = ptr_q;
            end
         endcase
      end else begin
         gnt_o = 2'b00;
         ptr_d = ptr_q;
      end
   end

   // Pointer register; 0 gives D0 priority out of reset.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: rtl/dest_fifo_reader.sv
// Read engine for destination FIFOs D0/D1: round-robin pops, 2-cycle
// registered output with destination tag, per-destination counters, sticky error.
module dest_fifo_reader
   import dest_fifo_reader_pkg::*;
#(
   parameter int BW    = 6,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               reset_L,
   dest_fifo_reader_if.master bus
);
   state_e           state_q, state_d;
   logic             inflight_q, inflight_d;
   logic             tag_q, tag_d;
   logic [BW-1:0]    out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_dest_q, out_dest_d;
   logic [CNT_W-1:0] cnt_d0_q, cnt_d0_d;
   logic [CNT_W-1:0] cnt_d1_q, cnt_d1_d;
   logic             error_q, error_d;

   logic             err_in_s;
   logic             any_ne_s;
   logic             rd_en_s;
   logic [1:0]       req_s;
   logic [1:0]       gnt_s;

   assign err_in_s = bus.D0_error_output | bus.D1_error_output;
   assign req_s    = {~bus.D1_empty, ~bus.D0_empty};
   assign any_ne_s = |req_s;
   assign rd_en_s  = (state_q == READ) && !bus.out_pause;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset_L (reset_L),
      .en_i    (rd_en_s),
      .req_i   (req_s),
      .gnt_o   (gnt_s)
   );

   // FSM next state; a FIFO error overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (err_in_s) begin
         state_d = ERROR;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_ne_s) state_d = READ;
               else          state_d = IDLE;
            end
            READ: begin
               if (bus.out_pause)  state_d = PAUSE;
               else if (!any_ne_s) state_d = IDLE;
               else                state_d = READ;
            end
            PAUSE: begin
               if (!any_ne_s)          state_d = IDLE;
               else if (!bus.out_pause) state_d = READ;
               else                    state_d = PAUSE;
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
         endcase
      end
   end

   // In-flight tracking and output capture; an error drops both the word
   // being captured and any pop issued in the same cycle.
   always_comb begin
      inflight_d  = 1'b0;
      tag_d       = tag_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
      cnt_d0_d    = cnt_d0_q;
      cnt_d1_d    = cnt_d1_q;
      error_d     = error_q;
      if (err_in_s) begin
         error_d = 1'b1;
      end else begin
         inflight_d = |gnt_s;
         if (|gnt_s) begin
            tag_d = gnt_to_dest(gnt_s);
         end else begin
            tag_d = tag_q;
         end
         if (inflight_q) begin
            out_valid_d = 1'b1;
            out_dest_d  = tag_q;
            if (tag_q == DEST_D1) begin
               out_data_d = bus.D1_data_out;
               cnt_d1_d   = cnt_d1_q + CNT_W'(1'b1);
            end else begin
               out_data_d = bus.D0_data_out;
               cnt_d0_d   = cnt_d0_q + CNT_W'(1'b1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= IDLE;
         inflight_q  <= 1'b0;
         tag_q       <= DEST_D0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_dest_q  <= DEST_D0;
         cnt_d0_q    <= '0;
         cnt_d1_q    <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         tag_q       <= tag_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_dest_q  <= out_dest_d;
         cnt_d0_q    <= cnt_d0_d;
         cnt_d1_q    <= cnt_d1_d;
         error_q     <= error_d;
      end
   end

   assign bus.D0_rd     = gnt_s[0];
   assign bus.D1_rd     = gnt_s[1];
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_dest  = out_dest_q;
   assign bus.cnt_D0    = cnt_d0_q;
   assign bus.cnt_D1    = cnt_d1_q;
   assign bus.error     = error_q;
   assign bus.idle      = (state_q == IDLE);
endmodule

// File: tb/tb_dest_fifo_reader.sv
// Bench for dest_fifo_reader: behavioural FIFOs with registered data/empty,
// per-destination scoreboard filled at load time, cycle tables and sequences.
module tb_dest_fifo_reader;
   import dest_fifo_reader_pkg::*;

   localparam int BW    = 6;
   localparam int CNT_W = 5;

   typedef struct {
      logic          pause;
      logic          rd0;
      logic          rd1;
      logic          valid;
      logic [BW-1:0] data;
      logic          dest;
      logic          idle;
   } vec_t;

   logic clk;
   logic reset_L;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [BW-1:0] d0_mem[$];
   logic [BW-1:0] d1_mem[$];
   logic [BW-1:0] exp0[$];
   logic [BW-1:0] exp1[$];

   dest_fifo_reader_if #(.BW(BW), .CNT_W(CNT_W)) bus ();

   dest_fifo_reader #(.BW(BW), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s", name, why);
   endtask

   // FIFO models: pop and empty flag both registered at the pop edge.
   always @(posedge clk) begin
      if (bus.D0_rd && d0_mem.size() > 0) bus.D0_data_out <= d0_mem.pop_front();
      if (bus.D1_rd && d1_mem.size() > 0) bus.D1_data_out <= d1_mem.pop_front();
      bus.D0_empty <= (d0_mem.size() == 0);
      bus.D1_empty <= (d1_mem.size() == 0);
   end

   // Scoreboard: every delivered word must match the next loaded word of its destination.
   always @(negedge clk) begin
      if (reset_L && bus.out_valid) begin
         if (bus.out_dest == DEST_D0) begin
            if (exp0.size() == 0) fail("sb_d0", "word delivered from D0 with none expected");
            else chk("sb_d0_data", 32'(bus.out_data), 32'(exp0.pop_front()));
         end else begin
            if (exp1.size() == 0) fail("sb_d1", "word delivered from D1 with none expected");
            else chk("sb_d1_data", 32'(bus.out_data), 32'(exp1.pop_front()));
         end
      end
   end

   task automatic do_reset();
      reset_L             = 1'b0;
      bus.out_pause       = 1'b0;
      bus.D0_error_output = 1'b0;
      bus.D1_error_output = 1'b0;
      d0_mem.delete();
      d1_mem.delete();
      exp0.delete();
      exp1.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic load(input logic dest, input logic [BW-1:0] w);
      if (dest) begin
         d1_mem.push_back(w);
         exp1.push_back(w);
      end else begin
         d0_mem.push_back(w);
         exp0.push_back(w);
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_D0_rd"},     32'(bus.D0_rd),     32'd0);
      chk({tag, "_D1_rd"},     32'(bus.D1_rd),     32'd0);
      chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_dest"},  32'(bus.out_dest),  32'd0);
      chk({tag, "_cnt_D0"},    32'(bus.cnt_D0),    32'd0);
      chk({tag, "_cnt_D1"},    32'(bus.cnt_D1),    32'd0);
      chk({tag, "_error"},     32'(bus.error),     32'd0);
      chk({tag, "_idle"},      32'(bus.idle),      32'd1);
   endtask

   task automatic wait_done(input int budget, input string name);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (k < budget && !done) begin
         done = bus.idle && !bus.out_valid && d0_mem.size() == 0 && d1_mem.size() == 0;
         if (!done) begin
            @(negedge clk);
            k++;
         end
      end
      if (!done) fail(name, "timed out waiting for FIFOs to drain");
      chk({name, "_exp0_left"}, 32'(exp0.size()), 32'd0);
      chk({name, "_exp1_left"}, 32'(exp1.size()), 32'd0);
   endtask

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[8];
      logic [7:0]    rdb;
      logic [7:0]    vb;
      int            pv;
      int            w;
      bit            got;

      // D0={1,2}, D1={10,11}: sampled once per cycle starting at reset release.
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd1,  1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd10, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd11, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1};

      // Reset state.
      do_reset();
      check_reset_vals("rst");

      // D0 holds A,B,C: three back-to-back pops, outputs two cycles later.
      load(1'b0, 6'h0A);
      load(1'b0, 6'h0B);
      load(1'b0, 6'h0C);
      release_rst();
      rdb = '0;
      vb  = '0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         rdb[i] = bus.D0_rd;
         vb[i]  = bus.out_valid;
      end
      chk("t1_rd_pattern",    32'(rdb), 32'h0E);
      chk("t1_valid_pattern", 32'(vb),  32'h38);
      chk("t1_cnt_D0", 32'(bus.cnt_D0), 32'd3);
      chk("t1_cnt_D1", 32'(bus.cnt_D1), 32'd0);
      chk("t1_idle",   32'(bus.idle),   32'd1);
      wait_done(20, "t1");

      // Round-robin between two loaded FIFOs, table driven.
      do_reset();
      load(1'b0, 6'd1);
      load(1'b0, 6'd2);
      load(1'b1, 6'd10);
      load(1'b1, 6'd11);
      release_rst();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         bus.out_pause = vecs[i].pause;
         #1;
         chk($sformatf("t2_v%0d_D0_rd", i),     32'(bus.D0_rd),     32'(vecs[i].rd0));
         chk($sformatf("t2_v%0d_D1_rd", i),     32'(bus.D1_rd),     32'(vecs[i].rd1));
         chk($sformatf("t2_v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
         chk($sformatf("t2_v%0d_idle", i),      32'(bus.idle),      32'(vecs[i].idle));
         if (vecs[i].valid) begin
            chk($sformatf("t2_v%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].data));
            chk($sformatf("t2_v%0d_out_dest", i), 32'(bus.out_dest), 32'(vecs[i].dest));
         end
      end
      chk("t2_cnt_D0", 32'(bus.cnt_D0), 32'd2);
      chk("t2_cnt_D1", 32'(bus.cnt_D1), 32'd2);
      wait_done(20, "t2");

      // Pause for four cycles mid-stream.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         load(1'b0, 6'(6'h10 + i));
         load(1'b1, 6'(6'h20 + i));
      end
      release_rst();
      repeat (4) @(negedge clk);
      bus.out_pause = 1'b1;
      pv = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t3_pause%0d_rd", k), 32'({bus.D1_rd, bus.D0_rd}), 32'd0);
         @(negedge clk);
         if (bus.out_valid) pv++;
      end
      bus.out_pause = 1'b0;
      chk("t3_valid_after_pause_gt1", 32'(pv > 1), 32'd0);
      w   = 0;
      got = 1'b0;
      while (w < 3 && !got) begin
         #1;
         got = bus.D0_rd | bus.D1_rd;
         if (!got) begin
            @(negedge clk);
            w++;
         end
      end
      chk("t3_resume", 32'(got), 32'd1);
      wait_done(60, "t3");
      chk("t3_cnt_D0", 32'(bus.cnt_D0), 32'd6);
      chk("t3_cnt_D1", 32'(bus.cnt_D1), 32'd6);

      // 33 words through D1: counter wraps to 1.
      do_reset();
      for (int i = 0; i < 33; i++) load(1'b1, 6'(i));
      release_rst();
      wait_done(150, "t4");
      chk("t4_cnt_D1_wrap", 32'(bus.cnt_D1), 32'd1);
      chk("t4_cnt_D0",      32'(bus.cnt_D0), 32'd0);

      // D1 error pulse while streaming: sticky ERROR, no pops, no output.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         load(1'b0, 6'(6'h08 + i));
         load(1'b1, 6'(6'h30 + i));
      end
      release_rst();
      repeat (6) @(negedge clk);
      bus.D1_error_output = 1'b1;
      @(negedge clk);
      bus.D1_error_output = 1'b0;
      #1;
      chk("t5_error", 32'(bus.error), 32'd1);
      chk("t5_idle",  32'(bus.idle),  32'd0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         chk($sformatf("t5_err%0d_rd", k),    32'({bus.D1_rd, bus.D0_rd}), 32'd0);
         chk($sformatf("t5_err%0d_valid", k), 32'(bus.out_valid),          32'd0);
      end
      chk("t5_error_sticky", 32'(bus.error), 32'd1);
      do_reset();
      check_reset_vals("t5_rst");
      release_rst();
      #1;
      chk("t5_post_error", 32'(bus.error), 32'd0);
      chk("t5_post_idle",  32'(bus.idle),  32'd1);

      // Asynchronous reset while a word is in flight.
      do_reset();
      for (int i = 0; i < 4; i++) load(1'b0, 6'(6'h31 + i));
      release_rst();
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         #1;
         got = bus.out_valid && bus.D0_rd;
      end
      if (!got) fail("t6_setup", "no cycle with pop and output together");
      @(posedge clk);
      #2;
      reset_L = 1'b0;
      #1;
      check_reset_vals("t6_async");
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
